byte_ram_bridge: RTL and testbench

- Synthesizable memory-side stage directly downstream of the ALU's data/instruction memory port.
- Accepts the ALU's single-word readReq/writeReq handshake and serves each request as four sequential byte accesses to a byte-wide synchronous SRAM.
- Words are little-endian; the SRAM is byte-addressed.
- Replaces the behavioural RAM model for synthesis.

---
 rtl/byte_ram_bridge.sv | 136 +++++++++++++
 tb/tb_byte_ram_bridge.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/byte_ram_bridge.sv
// Serves the ALU's word readReq/writeReq as four little-endian byte accesses to a byte-wide sync SRAM.
// Read ack 5 clocks, write ack 4 clocks after the sampling edge; new requests are ignored until back in IDLE.
module byte_ram_bridge #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ramAddress,
  input  logic [31:0]       ramOut,
  input  logic              readReq,
  input  logic              writeReq,
  output logic [31:0]       ramValue,
  output logic              readAck,
  output logic              writeAck,
  output logic [ADDR_W-1:0] memAddr,
  output logic [7:0]        memWData,
  output logic              memWe,
  input  logic [7:0]        memRData
);

  typedef enum logic [1:0] {IDLE, RD, WR, ACK} state_t;

  state_t              state_q, state_d;
  logic [2:0]          idx_q, idx_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [31:0]         ram_value_q, ram_value_d;
  logic                read_ack_q, read_ack_d;
  logic                write_ack_q, write_ack_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [7:0]          mem_wdata_q, mem_wdata_d;
  logic                mem_we_q, mem_we_d;
  logic [1:0]          rd_lane, wr_lane;

  // Address bits above the SRAM range alias by design.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ramAddress[31:ADDR_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      req_addr_q  <= '0;
      wdata_q     <= 32'd0;
      ram_value_q <= 32'd0;
      read_ack_q  <= 1'b0;
      write_ack_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      mem_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      req_addr_q  <= req_addr_d;
      wdata_q     <= wdata_d;
      ram_value_q <= ram_value_d;
      read_ack_q  <= read_ack_d;
      write_ack_q <= write_ack_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    req_addr_d  = req_addr_q;
    wdata_d     = wdata_q;
    ram_value_d = ram_value_q;
    read_ack_d  = 1'b0;
    write_ack_d = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = 1'b0;
    // SRAM data lags its address by one cycle, so idx=k returns byte k-1.
    rd_lane     = idx_q[1:0] - 2'd1;
    wr_lane     = idx_q[1:0] + 2'd1;

    case (state_q)
      IDLE: begin
        if (writeReq) begin
          state_d     = WR;
          idx_d       = 3'd0;
          req_addr_d  = ramAddress[ADDR_W-1:0];
          wdata_d     = ramOut;
          mem_addr_d  = ramAddress[ADDR_W-1:0];
          mem_wdata_d = ramOut[7:0];
          mem_we_d    = 1'b1;
        end else if (readReq) begin
          state_d    = RD;
          idx_d      = 3'd0;
          req_addr_d = ramAddress[ADDR_W-1:0];
          mem_addr_d = ramAddress[ADDR_W-1:0];
        end
      end
      RD: begin
        if (idx_q != 3'd0) begin
          ram_value_d[{rd_lane, 3'b000} +: 8] = memRData;
        end
        if (idx_q == 3'd4) begin
          read_ack_d = 1'b1;
          state_d    = ACK;
        end else begin
          idx_d      = idx_q + 3'd1;
          mem_addr_d = req_addr_q + ADDR_W'(idx_q + 3'd1);
        end
      end
      WR: begin
        if (idx_q == 3'd3) begin
          write_ack_d = 1'b1;
          state_d     = ACK;
        end else begin
          idx_d       = idx_q + 3'd1;
          mem_we_d    = 1'b1;
          mem_addr_d  = req_addr_q + ADDR_W'(idx_q + 3'd1);
          mem_wdata_d = wdata_q[{wr_lane, 3'b000} +: 8];
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ramValue = ram_value_q;
  assign readAck  = read_ack_q;
  assign writeAck = write_ack_q;
  assign memAddr  = mem_addr_q;
  assign memWData = mem_wdata_q;
  assign memWe    = mem_we_q;

endmodule

// File: tb/tb_byte_ram_bridge.sv
// Directed bench for byte_ram_bridge against a byte-wide synchronous SRAM model.
module tb_byte_ram_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] ramAddress = 32'd0;
  logic [31:0] ramOut = 32'd0;
  logic        readReq = 1'b0;
  logic        writeReq = 1'b0;
  logic [31:0] ramValue;
  logic        readAck;
  logic        writeAck;
  logic [10:0] memAddr;
  logic [7:0]  memWData;
  logic        memWe;
  logic [7:0]  memRData;

  logic [7:0]  sram [0:2047];
  int          vectors = 0;
  int          errors = 0;

  byte_ram_bridge #(.ADDR_W(11)) dut (
    .clk(clk), .reset(reset), .ramAddress(ramAddress), .ramOut(ramOut),
    .readReq(readReq), .writeReq(writeReq), .ramValue(ramValue),
    .readAck(readAck), .writeAck(writeAck), .memAddr(memAddr),
    .memWData(memWData), .memWe(memWe), .memRData(memRData)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (memWe) sram[memAddr] <= memWData;
    memRData <= sram[memAddr];
  end

  // Issues one request, drops it after the sampling edge, then watches acks for 12 clocks.
  task automatic op(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                    output int rlat, output int wlat, output int rcnt, output int wcnt,
                    output logic [31:0] val);
    rlat = -1; wlat = -1; rcnt = 0; wcnt = 0; val = 32'hx;
    @(negedge clk);
    ramAddress = a; ramOut = d; readReq = rd; writeReq = wr;
    @(posedge clk);
    @(negedge clk);
    readReq = 1'b0; writeReq = 1'b0; ramAddress = 32'hFFFF_FFFF; ramOut = 32'h0;
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (readAck) begin
        rcnt++;
        if (rlat < 0) begin rlat = n; val = ramValue; end
      end
      if (writeAck) begin
        wcnt++;
        if (wlat < 0) wlat = n;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    vectors++;
    if ({ramValue, readAck, writeAck, memAddr, memWData, memWe} !== 54'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {ramValue, readAck, writeAck, memAddr, memWData, memWe});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_read();
    int rl, wl, rc, wc; logic [31:0] v;
    op(1'b1, 1'b0, 32'h10, 32'h0, rl, wl, rc, wc, v);
    vectors++; if (rl !== 5) begin errors++; $display("FAIL read_latency: got %0d expected 5", rl); end
    vectors++; if (rc !== 1) begin errors++; $display("FAIL read_ack_cycles: got %0d expected 1", rc); end
    vectors++; if (wc !== 0) begin errors++; $display("FAIL read_no_wack: got %0d expected 0", wc); end
    vectors++; if (v !== 32'h44332211) begin errors++; $display("FAIL read_value: got %h expected 44332211", v); end
  endtask

  task automatic test_write_readback();
    int rl, wl, rc, wc; logic [31:0] v;
    op(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, rl, wl, rc, wc, v);
    vectors++; if (wl !== 4) begin errors++; $display("FAIL write_latency: got %0d expected 4", wl); end
    vectors++; if (wc !== 1) begin errors++; $display("FAIL write_ack_cycles: got %0d expected 1", wc); end
    vectors++; if (rc !== 0) begin errors++; $display("FAIL write_no_rack: got %0d expected 0", rc); end
    vectors++;
    if ({sram[11'h23], sram[11'h22], sram[11'h21], sram[11'h20]} !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL write_bytes: got %h expected deadbeef",
               {sram[11'h23], sram[11'h22], sram[11'h21], sram[11'h20]});
    end
    op(1'b1, 1'b0, 32'h20, 32'h0, rl, wl, rc, wc, v);
    vectors++; if (v !== 32'hDEADBEEF) begin errors++; $display("FAIL readback: got %h expected deadbeef", v); end
  endtask

  task automatic test_priority();
    int rl, wl, rc, wc; logic [31:0] v;
    op(1'b1, 1'b1, 32'h30, 32'h01020304, rl, wl, rc, wc, v);
    vectors++; if (wl !== 4) begin errors++; $display("FAIL prio_write_latency: got %0d expected 4", wl); end
    vectors++; if (rc !== 0) begin errors++; $display("FAIL prio_no_rack: got %0d expected 0", rc); end
    vectors++;
    if ({sram[11'h33], sram[11'h32], sram[11'h31], sram[11'h30]} !== 32'h01020304) begin
      errors++;
      $display("FAIL prio_bytes: got %h expected 01020304",
               {sram[11'h33], sram[11'h32], sram[11'h31], sram[11'h30]});
    end
  endtask

  task automatic test_wrap();
    int rl, wl, rc, wc; logic [31:0] v;
    op(1'b0, 1'b1, 32'h7FE, 32'hA1B2C3D4, rl, wl, rc, wc, v);
    vectors++;
    if ({sram[11'h001], sram[11'h000], sram[11'h7FF], sram[11'h7FE]} !== 32'hA1B2C3D4) begin
      errors++;
      $display("FAIL wrap_bytes: got %h expected a1b2c3d4",
               {sram[11'h001], sram[11'h000], sram[11'h7FF], sram[11'h7FE]});
    end
    op(1'b1, 1'b0, 32'h7FE, 32'h0, rl, wl, rc, wc, v);
    vectors++; if (v !== 32'hA1B2C3D4) begin errors++; $display("FAIL wrap_readback: got %h expected a1b2c3d4", v); end
  endtask

  task automatic test_alias();
    int rl, wl, rc, wc; logic [31:0] v;
    op(1'b1, 1'b0, 32'h00000810, 32'h0, rl, wl, rc, wc, v);
    vectors++; if (v !== 32'h44332211) begin errors++; $display("FAIL alias_read: got %h expected 44332211", v); end
    op(1'b0, 1'b1, 32'h80000825, 32'hCAFEF00D, rl, wl, rc, wc, v);
    vectors++;
    if ({sram[11'h28], sram[11'h27], sram[11'h26], sram[11'h25]} !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL alias_misaligned_write: got %h expected cafef00d",
               {sram[11'h28], sram[11'h27], sram[11'h26], sram[11'h25]});
    end
  endtask

  task automatic test_held_read();
    int pos[$]; int back_to_back; logic prev; logic [31:0] last;
    back_to_back = 0; prev = 1'b0; last = 32'h0;
    @(negedge clk);
    ramAddress = 32'h10; readReq = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 21; n++) begin
      @(posedge clk);
      @(negedge clk);
      if (readAck) begin
        pos.push_back(n);
        last = ramValue;
        if (prev) back_to_back++;
      end
      prev = readAck;
    end
    readReq = 1'b0;
    repeat (10) @(negedge clk);
    vectors++; if (pos.size() !== 3) begin errors++; $display("FAIL held_ack_count: got %0d expected 3", pos.size()); end
    vectors++;
    if (pos.size() >= 3 && (pos[0] != 5 || pos[1] != 12 || pos[2] != 19)) begin
      errors++;
      $display("FAIL held_ack_spacing: got %0d,%0d,%0d expected 5,12,19", pos[0], pos[1], pos[2]);
    end
    vectors++; if (back_to_back !== 0) begin errors++; $display("FAIL held_consecutive_acks: got %0d expected 0", back_to_back); end
    vectors++; if (last !== 32'h44332211) begin errors++; $display("FAIL held_value: got %h expected 44332211", last); end
  endtask

  task automatic test_reset_midop_read();
    int rl, wl, rc, wc; logic [31:0] v;
    @(negedge clk);
    ramAddress = 32'h20; readReq = 1'b1;
    @(posedge clk);
    @(negedge clk);
    readReq = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    vectors++; if (ramValue !== 32'h4433BEEF) begin errors++; $display("FAIL partial_read_value: got %h expected 4433beef", ramValue); end
    reset = 1'b1;
    #1;
    vectors++;
    if ({ramValue, readAck, writeAck, memAddr, memWData, memWe} !== 54'd0) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h expected 0",
               {ramValue, readAck, writeAck, memAddr, memWData, memWe});
    end
    @(negedge clk);
    reset = 1'b0;
    op(1'b0, 1'b1, 32'h50, 32'h11223344, rl, wl, rc, wc, v);
    vectors++; if (wl !== 4) begin errors++; $display("FAIL post_reset_idle: got %0d expected 4", wl); end
  endtask

  task automatic test_reset_midop_write();
    int ack_seen;
    ack_seen = 0;
    @(negedge clk);
    ramAddress = 32'h40; ramOut = 32'hDEADBEEF; writeReq = 1'b1;
    @(posedge clk);
    @(negedge clk);
    writeReq = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    vectors++; if (memWe !== 1'b0) begin errors++; $display("FAIL abort_memwe: got %b expected 0", memWe); end
    repeat (2) begin @(negedge clk); if (writeAck) ack_seen++; end
    reset = 1'b0;
    repeat (8) begin @(negedge clk); if (writeAck) ack_seen++; end
    vectors++; if (ack_seen !== 0) begin errors++; $display("FAIL abort_no_wack: got %0d expected 0", ack_seen); end
    vectors++;
    if ({sram[11'h43], sram[11'h42], sram[11'h41], sram[11'h40]} !== 32'h5555BEEF) begin
      errors++;
      $display("FAIL abort_bytes: got %h expected 5555beef",
               {sram[11'h43], sram[11'h42], sram[11'h41], sram[11'h40]});
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) sram[i] = 8'h00;
    sram[11'h10] = 8'h11; sram[11'h11] = 8'h22; sram[11'h12] = 8'h33; sram[11'h13] = 8'h44;
    for (int i = 11'h40; i < 11'h44; i++) sram[i] = 8'h55;
    test_reset();
    test_read();
    test_write_readback();
    test_priority();
    test_wrap();
    test_alias();
    test_held_read();
    test_reset_midop_read();
    test_reset_midop_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
